// File: rtl/fifo_buffer.sv
// Circular-buffer FIFO between valid/ready producer and consumer; optional FIFO_BUFFER_BYPASS_EN adds empty-path bypass.
// Latency: 1 cycle push->head (0 with bypass when empty). Backpressure: rdy_o drops when full (PASS_READY lets a pop free a slot) or on flush.
module fifo_buffer #(
    parameter type         t            = logic,
    parameter int unsigned DEPTH        = 4,
    parameter bit          PASS_READY   = 1'b1,
    parameter int unsigned AFULL_THRESH = DEPTH - 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  t                           din_i,
    input  logic                       vld_i,
    output logic                       rdy_o,
    output t                           dout_o,
    output logic                       vld_o,
    input  logic                       rdy_i,
    output logic [$clog2(DEPTH+1)-1:0] fill_o,
    output logic                       almost_full_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_THRESH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    t              mem_q [DEPTH];
    t              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic empty, full, push, pop, wr_en, rd_en, bypass;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == DEPTH_C);
        // When full, a same-cycle pop frees the slot the write will land in.
        rdy_o = ~flush_i & (~full | (PASS_READY & rdy_i));
`ifdef FIFO_BUFFER_BYPASS_EN
        bypass = empty & vld_i & ~flush_i;
`else
        bypass = 1'b0;
`endif
        vld_o  = ~empty | bypass;
        dout_o = bypass ? din_i : mem_q[rd_ptr_q];
        push   = vld_i & rdy_o;
        pop    = vld_o & rdy_i;
        // A bypassed element consumed in the same cycle never touches storage.
        wr_en  = push & ~(bypass & rdy_i);
        rd_en  = pop & ~bypass;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (rd_en) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign fill_o        = count_q;
    assign almost_full_o = (count_q >= AFULL_C);

endmodule

// File: tb/tb_fifo_buffer.sv
// Scoreboard bench for fifo_buffer: three instances (D4/PR0, D4/PR1, D3/PR1) with per-instance queue monitors.
module tb_fifo_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] din   [3];
    logic       vld_i [3];
    logic       rdy_i [3];
    logic       flush [3];
    logic [7:0] dout  [3];
    logic       vld_o [3];
    logic       rdy_o [3];
    logic       af    [3];
    logic [2:0] fill  [3];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D  = (g == 2) ? 3 : 4;
        localparam bit PR = (g != 0);
        localparam int AF = D - 1;

        logic [$clog2(D+1)-1:0] fill_w;
        logic [7:0]             q[$];
        logic [7:0]             exp_d;
        logic                   exp_vld;
        int                     pops = 0;

        fifo_buffer #(.t(logic [7:0]), .DEPTH(D), .PASS_READY(PR)) u_dut (
            .clk_i(clk), .rst_i(rst), .flush_i(flush[g]),
            .din_i(din[g]), .vld_i(vld_i[g]), .rdy_o(rdy_o[g]),
            .dout_o(dout[g]), .vld_o(vld_o[g]), .rdy_i(rdy_i[g]),
            .fill_o(fill_w), .almost_full_o(af[g])
        );
        assign fill[g] = 3'(fill_w);

        always @(negedge clk) begin
            if (rst) begin
                q.delete();
            end else begin
                exp_vld = (q.size() != 0);
`ifdef FIFO_BUFFER_BYPASS_EN
                exp_vld = exp_vld | (vld_i[g] & ~flush[g]);
`endif
                chk($sformatf("mon%0d_fill", g), 32'(fill[g]), q.size());
                chk($sformatf("mon%0d_vld", g), 32'(vld_o[g]), 32'(exp_vld));
                chk($sformatf("mon%0d_afull", g), 32'(af[g]), 32'(q.size() >= AF));
                chk($sformatf("mon%0d_rdy", g), 32'(rdy_o[g]),
                    32'(!flush[g] && (q.size() < D || (PR && rdy_i[g]))));
                if (vld_i[g] && rdy_o[g]) q.push_back(din[g]);
                if (vld_o[g] && rdy_i[g]) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL mon%0d_pop_empty: got %0h expected no pop", g, dout[g]);
                    end else begin
                        exp_d = q.pop_front();
                        pops++;
                        if (dout[g] !== exp_d) begin
                            errors++;
                            $display("FAIL mon%0d_dout: got %0h expected %0h", g, dout[g], exp_d);
                        end
                    end
                end
                if (flush[g]) q.delete();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    int sent;
    int maxfill;

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[k] = '0; vld_i[k] = 1'b0; rdy_i[k] = 1'b0; flush[k] = 1'b0;
        end
        repeat (3) step();
        // 1: reset state
        for (int k = 0; k < 3; k++) begin
            chk("rst_vld", 32'(vld_o[k]), 0);
            chk("rst_rdy", 32'(rdy_o[k]), 1);
            chk("rst_fill", 32'(fill[k]), 0);
            chk("rst_afull", 32'(af[k]), 0);
            chk("rst_dout", 32'(dout[k]), 0);
        end
        rst = 1'b0;
        step();

        // 2: PASS_READY=0 fill then drain
        vld_i[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din[0] = 8'h11 * (i + 1);
            @(negedge clk);
            chk("t2_fill", 32'(fill[0]), i);
            chk("t2_afull", 32'(af[0]), (i >= 3) ? 1 : 0);
            chk("t2_rdy", 32'(rdy_o[0]), 1);
            step();
        end
        din[0] = 8'h99;
        @(negedge clk);
        chk("t2_full_fill", 32'(fill[0]), 4);
        chk("t2_full_rdy", 32'(rdy_o[0]), 0);
        chk("t2_full_afull", 32'(af[0]), 1);
        step();
        rdy_i[0] = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 0) chk("t2_rdy_no_pass", 32'(rdy_o[0]), 0);
            chk("t2_dout", 32'(dout[0]), 8'h11 * (j + 1));
            chk("t2_drain_fill", 32'(fill[0]), 4 - j);
            step();
            vld_i[0] = 1'b0;
        end
        @(negedge clk);
        chk("t2_empty_vld", 32'(vld_o[0]), 0);
        step();
        rdy_i[0] = 1'b0;

        // 3: PASS_READY=1 full streaming across wrap
        vld_i[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din[1] = 8'hA0 + 8'(i);
            step();
        end
        din[1] = 8'hEE;
        @(negedge clk);
        chk("t3_full_rdy", 32'(rdy_o[1]), 0);
        chk("t3_full_fill", 32'(fill[1]), 4);
        step();
        rdy_i[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            din[1] = 8'hB0 + 8'(c);
            @(negedge clk);
            chk("t3_fill", 32'(fill[1]), 4);
            chk("t3_rdy", 32'(rdy_o[1]), 1);
            chk("t3_dout", 32'(dout[1]), (c < 4) ? (8'hA0 + c) : (8'hB0 + c - 4));
            step();
        end
        vld_i[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("t3_tail", 32'(dout[1]), 8'hB6 + j);
            step();
        end
        @(negedge clk);
        chk("t3_empty_vld", 32'(vld_o[1]), 0);
        step();
        rdy_i[1] = 1'b0;

        // 4: flush at fill 3
        vld_i[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din[1] = 8'hC0 + 8'(i);
            step();
        end
        flush[1] = 1'b1;
        din[1] = 8'hEE;
        @(negedge clk);
        chk("t4_flush_rdy", 32'(rdy_o[1]), 0);
        chk("t4_flush_fill", 32'(fill[1]), 3);
        step();
        flush[1] = 1'b0;
        vld_i[1] = 1'b0;
        @(negedge clk);
        chk("t4_post_fill", 32'(fill[1]), 0);
        chk("t4_post_vld", 32'(vld_o[1]), 0);
        step();
        vld_i[1] = 1'b1;
        din[1] = 8'h5A;
        step();
        vld_i[1] = 1'b0;
        @(negedge clk);
        chk("t4_head_vld", 32'(vld_o[1]), 1);
        chk("t4_head_dout", 32'(dout[1]), 8'h5A);
        chk("t4_head_fill", 32'(fill[1]), 1);
        step();
        rdy_i[1] = 1'b1;
        step();
        rdy_i[1] = 1'b0;
        @(negedge clk);
        chk("t4_drained", 32'(fill[1]), 0);
        step();

        // 5: DEPTH=3 random handshakes, 30 items
        sent = 0;
        maxfill = 0;
        for (int c = 0; c < 400 && !(c >= 200 && sent == 30); c++) begin
            vld_i[2] = (sent < 30) && ($urandom_range(0, 1) == 1);
            din[2]   = 8'h40 + 8'(sent);
            rdy_i[2] = ($urandom_range(0, 2) == 0);
            @(negedge clk);
            if (int'(fill[2]) > maxfill) maxfill = int'(fill[2]);
            if (vld_i[2] && rdy_o[2]) sent++;
            step();
        end
        vld_i[2] = 1'b0;
        rdy_i[2] = 1'b1;
        repeat (6) step();
        rdy_i[2] = 1'b0;
        @(negedge clk);
        chk("t5_sent", sent, 30);
        chk("t5_popped", g_dut[2].pops, 30);
        chk("t5_maxfill_le3", 32'(maxfill <= 3), 1);
        chk("t5_end_fill", 32'(fill[2]), 0);
        step();

        // 6: asynchronous reset mid-cycle with fill 2
        vld_i[1] = 1'b1;
        din[1] = 8'hD0;
        step();
        din[1] = 8'hD1;
        step();
        vld_i[1] = 1'b0;
        chk("t6_pre_fill", 32'(fill[1]), 2);
        #1 rst = 1'b1;
        #1;
        chk("t6_async_vld", 32'(vld_o[1]), 0);
        chk("t6_async_fill", 32'(fill[1]), 0);
        chk("t6_async_dout", 32'(dout[1]), 0);
        chk("t6_async_rdy", 32'(rdy_o[1]), 1);
        step();
        rst = 1'b0;
        step();

`ifdef FIFO_BUFFER_BYPASS_EN
        vld_i[1] = 1'b1;
        rdy_i[1] = 1'b1;
        din[1] = 8'h77;
        #1;
        chk("t6_bypass_dout", 32'(dout[1]), 8'h77);
        chk("t6_bypass_vld", 32'(vld_o[1]), 1);
        chk("t6_bypass_fill", 32'(fill[1]), 0);
        step();
        vld_i[1] = 1'b0;
        rdy_i[1] = 1'b0;
        @(negedge clk);
        chk("t6_bypass_after", 32'(fill[1]), 0);
        step();
`endif

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
- Parametrised multi-entry successor to the single-entry handshake slice.
- Circular-buffer FIFO between a valid/ready producer and a valid/ready consumer in the streaming datapath.
- Adds over the slice:
  - configurable depth, element type and ready pass-through;
  - fill-level and almost-full reporting;
  - synchronous flush.
- With DEPTH=1 and PASS_READY=1 it is cycle-equivalent to the slice.

Parameters:
- t, logic: element type carried on din_i/dout_o.
- DEPTH, 4: number of entries; must be >= 1; need not be a power of two.
- PASS_READY, 1: 1 = rdy_o may assert while full if rdy_i is high; 0 = rdy_o depends only on fill.
- AFULL_THRESH, DEPTH-1: almost_full_o asserts when fill >= this value; legal range 1..DEPTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous clear of all entries.
- din_i  in  t  input element.
- vld_i  in  1  input valid.
- rdy_o  out  1  input ready.
- dout_o  out  t  head element.
- vld_o  out  1  output valid.
- rdy_i  in  1  output ready.
- fill_o  out  $clog2(DEPTH+1)  number of stored entries.
- almost_full_o  out  1  fill_o >= AFULL_THRESH.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset, applied at any time including mid-transfer, takes effect immediately without waiting for a clock edge:
  - wr_ptr=0, rd_ptr=0, count=0, storage cleared to '0;
  - outputs: vld_o=0, dout_o='0, fill_o=0, almost_full_o=0;
  - rdy_o=1 unless flush_i=1.
- Transfers:
  - push = vld_i & rdy_o; pop = vld_o & rdy_i.
  - Data, pointers and count update on the rising edge.
- Output side:
  - vld_o = (count != 0); dout_o = mem[rd_ptr].
  - dout_o is registered storage, so there is no combinational din_i->dout_o path.
  - Latency: an element pushed at edge N is visible on dout_o/vld_o after edge N.
- Input side:
  - rdy_o = ~flush_i & ((count < DEPTH) | (PASS_READY & count==DEPTH & rdy_i)).
  - With PASS_READY=0, rdy_o has no dependence on rdy_i.
- Pointer wrap: each pointer increments on its own transfer and wraps from DEPTH-1 to 0.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: unchanged; both pointers advance.
- Full with simultaneous push and pop (PASS_READY=1): write goes to the slot being vacated (wr_ptr==rd_ptr). Sustained throughput is 1 element/cycle.
- Empty: vld_o=0, so no pop; pushes land at wr_ptr.
- vld_o and dout_o do not depend combinationally on vld_i.
- Flush:
  - When flush_i=1 at an edge, count and both pointers go to 0. Storage contents are don't-care.
  - rdy_o is forced 0 in a flush cycle, so no input is lost silently.
  - A pop in the flush cycle still completes: the consumer has taken the data.
  - Flush has priority over all other updates.
- Status outputs: fill_o = count; almost_full_o = (count >= AFULL_THRESH). Both are derived from registered state.
- Protocol: once vld_o is raised it is not dropped until pop or flush/reset, and dout_o stays stable over that interval.

Optional Feature:
- Macro: FIFO_BUFFER_BYPASS_EN.
- Defined:
  - When count==0 and vld_i=1 and flush_i=0: vld_o=1 and dout_o=din_i combinationally.
  - If rdy_i=1 in that cycle, the element is consumed without being written; count and pointers are unchanged.
  - If rdy_i=0, it is written normally.
  - Zero-cycle latency when empty.
- Undefined: no din_i->dout_o path; minimum latency 1 cycle as above.

Test Plan:
1. DEPTH=4, reset held then released, no traffic -> vld_o=0, rdy_o=1, fill_o=0, almost_full_o=0, dout_o=0.
2. PASS_READY=0, push 0x11,0x22,0x33,0x44 with rdy_i=0:
   - fill_o 1,2,3,4; almost_full_o asserts at fill 3; rdy_o=0 at fill 4.
   - Then rdy_i=1 -> dout_o 0x11,0x22,0x33,0x44 on consecutive cycles, then vld_o=0.
3. PASS_READY=1, full at 4 entries, vld_i=rdy_i=1 for 10 cycles with incrementing data:
   - fill_o stays 4 and rdy_o=1 throughout;
   - output order strictly matches input order across pointer wrap.
4. fill_o=3, flush_i=1 for one cycle with vld_i=1 -> rdy_o=0 in that cycle; next cycle fill_o=0, vld_o=0. A subsequent push of 0x5A appears as the head.
5. DEPTH=3, random vld_i/rdy_i for 200 cycles, 30 items -> scoreboard order preserved, fill_o always 0..3, never push when rdy_o=0.
6. fill_o=2, rst_i asserted mid-cycle -> vld_o=0 and fill_o=0 before the next clock edge.
   - With FIFO_BUFFER_BYPASS_EN: empty, vld_i=rdy_i=1, din_i=0x77 -> same-cycle dout_o=0x77, fill_o stays 0.
